// File: rtl/mines_pkg.sv
// Shared constants for the mine board controller: board size, cell codes,
// controller state encodings and a population-count helper.
package mines_pkg;

    localparam int BOARD = 8;

    // Cell codes; 0..8 are revealed neighbour counts
    localparam logic [3:0] CELL_BOOM = 4'hC;
    localparam logic [3:0] CELL_MINE = 4'hD;
    localparam logic [3:0] CELL_FLAG = 4'hE;
    localparam logic [3:0] CELL_HID  = 4'hF;

    // Controller states
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PLAY   = 3'd1;
    localparam logic [2:0] S_REVEAL = 3'd2;
    localparam logic [2:0] S_SWEEP  = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_LOST   = 3'd5;
    localparam logic [2:0] S_WON    = 3'd6;

    // Number of set bits in a 64-bit map (0..64 fits in 7 bits)
    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/mines_ctrl_neighbors.sv
// Combinational adjacent-mine counter for one board cell, clipped at the
// board edges so border cells only consider in-board neighbours.
module mine_neighbors
    import mines_pkg::*;
(
    input  logic [63:0] mine_q,
    input  logic [2:0]  x,
    input  logic [2:0]  y,
    output logic [3:0]  count
);

    // Sum the up-to-eight in-board neighbours that hold a mine
    always_comb begin
        count = '0;
        for (int dx = -1; dx <= 1; dx++) begin
            for (int dy = -1; dy <= 1; dy++) begin
                int nx;
                int ny;
                nx = int'(x) + dx;
                ny = int'(y) + dy;
                if (!(dx == 0 && dy == 0) && nx >= 0 && nx < BOARD &&
                    ny >= 0 && ny < BOARD) begin
                    if (mine_q[{3'(nx), 3'(ny)}]) begin
                        count = count + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mines_ctrl.sv
// Mine board game controller: owns the cell matrix, moves the cursor,
// handles flag/select actions, runs the flood-fill sweep and decides
// win/lose.
module mines_ctrl
    import mines_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [63:0]          mine_map,
    input  logic                 up,
    input  logic                 down,
    input  logic                 left,
    input  logic                 right,
    input  logic                 select,
    input  logic                 flag,
    output logic [2:0]           pos_x,
    output logic [2:0]           pos_y,
    output logic [7:0][7:0][3:0] matrizJuego,
    output logic [6:0]           flags_left,
    output logic                 busy,
    output logic                 game_over,
    output logic                 win
);

    logic [2:0]  state;
    logic [63:0] mine_q;
    logic [6:0]  rev_cnt;
    logic [2:0]  tgt_x, tgt_y;
    logic [5:0]  sidx;
    logic        changed;

    logic [2:0]  nxt_x, nxt_y;
    logic        move_ok;
    logic [3:0]  cur_cell;
    logic [3:0]  tgt_cnt;
    logic [3:0]  sw_cnt;
    logic        nb_zero;
    logic        sw_open;
    logic [2:0]  sx, sy;

    assign sx       = sidx[5:3];
    assign sy       = sidx[2:0];
    assign cur_cell = matrizJuego[pos_x][pos_y];
    assign move_ok  = (state == S_PLAY) || (state == S_REVEAL) ||
                      (state == S_SWEEP) || (state == S_CHECK);

    assign busy      = (state == S_REVEAL) || (state == S_SWEEP) || (state == S_CHECK);
    assign game_over = (state == S_LOST);
    assign win       = (state == S_WON);

    mine_neighbors u_nb_tgt (
        .mine_q (mine_q),
        .x      (tgt_x),
        .y      (tgt_y),
        .count  (tgt_cnt)
    );

    mine_neighbors u_nb_sweep (
        .mine_q (mine_q),
        .x      (sx),
        .y      (sy),
        .count  (sw_cnt)
    );

    // Next cursor position: wrap per axis, opposing pulses cancel
    always_comb begin
        nxt_x = pos_x;
        nxt_y = pos_y;
        if (right && !left) nxt_x = pos_x + 3'd1;
        else if (left && !right) nxt_x = pos_x - 3'd1;
        if (down && !up) nxt_y = pos_y + 3'd1;
        else if (up && !down) nxt_y = pos_y - 3'd1;
    end

    // Does any in-board neighbour of the sweep cell already show a zero
    always_comb begin
        nb_zero = 1'b0;
        for (int dx = -1; dx <= 1; dx++) begin
            for (int dy = -1; dy <= 1; dy++) begin
                int nx;
                int ny;
                nx = int'(sx) + dx;
                ny = int'(sy) + dy;
                if (!(dx == 0 && dy == 0) && nx >= 0 && nx < BOARD &&
                    ny >= 0 && ny < BOARD) begin
                    if (matrizJuego[3'(nx)][3'(ny)] == 4'd0) begin
                        nb_zero = 1'b1;
                    end
                end
            end
        end
    end

    // Flagged and revealed cells are never touched by the sweep
    assign sw_open = (matrizJuego[sx][sy] == CELL_HID) && nb_zero;

    // Controller state, board matrix, cursor and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            matrizJuego <= {64{CELL_HID}};
            pos_x       <= '0;
            pos_y       <= '0;
            flags_left  <= '0;
            mine_q      <= '0;
            rev_cnt     <= '0;
            tgt_x       <= '0;
            tgt_y       <= '0;
            sidx        <= '0;
            changed     <= 1'b0;
        end else if (start) begin
            state       <= S_PLAY;
            matrizJuego <= {64{CELL_HID}};
            pos_x       <= '0;
            pos_y       <= '0;
            flags_left  <= popcount64(mine_map);
            mine_q      <= mine_map;
            rev_cnt     <= '0;
            sidx        <= '0;
            changed     <= 1'b0;
        end else begin
            if (move_ok) begin
                pos_x <= nxt_x;
                pos_y <= nxt_y;
            end
            case (state)
                S_PLAY: begin
                    // Actions use the cursor as it was before this cycle's move
                    if (flag) begin
                        if (cur_cell == CELL_HID && flags_left != 7'd0) begin
                            matrizJuego[pos_x][pos_y] <= CELL_FLAG;
                            flags_left <= flags_left - 7'd1;
                        end else if (cur_cell == CELL_FLAG) begin
                            matrizJuego[pos_x][pos_y] <= CELL_HID;
                            flags_left <= flags_left + 7'd1;
                        end
                    end else if (select && cur_cell == CELL_HID) begin
                        if (mine_q[{pos_x, pos_y}]) begin
                            for (int i = 0; i < BOARD; i++) begin
                                for (int j = 0; j < BOARD; j++) begin
                                    if (mine_q[{3'(i), 3'(j)}] &&
                                        matrizJuego[i][j] != CELL_FLAG) begin
                                        matrizJuego[i][j] <= CELL_MINE;
                                    end
                                end
                            end
                            // Later NBA overrides the shown-mine code for the hit cell
                            matrizJuego[pos_x][pos_y] <= CELL_BOOM;
                            state <= S_LOST;
                        end else begin
                            tgt_x <= pos_x;
                            tgt_y <= pos_y;
                            state <= S_REVEAL;
                        end
                    end
                end
                S_REVEAL: begin
                    matrizJuego[tgt_x][tgt_y] <= tgt_cnt;
                    rev_cnt <= rev_cnt + 7'd1;
                    sidx    <= '0;
                    changed <= 1'b0;
                    state   <= (tgt_cnt == 4'd0) ? S_SWEEP : S_CHECK;
                end
                S_SWEEP: begin
                    if (sw_open) begin
                        matrizJuego[sx][sy] <= sw_cnt;
                        rev_cnt <= rev_cnt + 7'd1;
                    end
                    if (sidx == 6'd63) begin
                        sidx    <= '0;
                        changed <= 1'b0;
                        // A pass that opened nothing means the fill is complete
                        if (!(changed || sw_open)) state <= S_CHECK;
                    end else begin
                        sidx    <= sidx + 6'd1;
                        changed <= changed | sw_open;
                    end
                end
                S_CHECK: begin
                    state <= (rev_cnt == 7'd64 - popcount64(mine_q)) ? S_WON : S_PLAY;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mines_ctrl.sv
// Directed bench for mines_ctrl: a vector table for cursor/flag/reveal
// behaviour plus hand-written sequences for flood fill, mine hit and
// sweep interruption.
module tb_mines_ctrl;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [63:0]       mine_map = '0;
    logic              up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic              select = 1'b0, flag = 1'b0;
    logic [2:0]        pos_x, pos_y;
    logic [7:0][7:0][3:0] mat;
    logic [6:0]        flags_left;
    logic              busy, game_over, win;

    int checks = 0;
    int errors = 0;

    mines_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mine_map    (mine_map),
        .up          (up),
        .down        (down),
        .left        (left),
        .right       (right),
        .select      (select),
        .flag        (flag),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .matrizJuego (mat),
        .flags_left  (flags_left),
        .busy        (busy),
        .game_over   (game_over),
        .win         (win)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic u, d, l, r, sel, flg;
        int   px, py;
        int   ex, ey, efl, ecell, ebusy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic u, d, l, r, sel, flg,
                       input int px, py, ex, ey, efl, ecell, ebusy);
        vec_t v;
        v.u = u; v.d = d; v.l = l; v.r = r; v.sel = sel; v.flg = flg;
        v.px = px; v.py = py; v.ex = ex; v.ey = ey;
        v.efl = efl; v.ecell = ecell; v.ebusy = ebusy;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic u, d, l, r, sel, flg);
        up = u; down = d; left = l; right = r; select = sel; flag = flg;
        tick();
        up = 0; down = 0; left = 0; right = 0; select = 0; flag = 0;
    endtask

    task automatic do_start(input logic [63:0] m);
        mine_map = m;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic int count_not(input logic [3:0] code);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (mat[i][j] != code) n++;
        return n;
    endfunction

    localparam int F = 15, E = 14, D = 13, C = 12;

    initial begin
        int n;
        int bad;
        int expc;

        // Reset state
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("reset_cells_not_hidden", count_not(4'hF), 0);
        check("reset_pos_x", pos_x, 0);
        check("reset_pos_y", pos_y, 0);
        check("reset_flags", flags_left, 0);
        check("reset_busy", busy, 0);
        check("reset_game_over", game_over, 0);
        check("reset_win", win, 0);
        pulse(0, 0, 0, 1, 0, 0);
        check("idle_move_ignored", pos_x, 0);

        // Start with single mine at (0,0)
        do_start(64'h1);
        check("start_cells_hidden", count_not(4'hF), 0);
        check("start_flags", flags_left, 1);
        check("start_pos", {pos_x, pos_y}, 0);
        check("start_busy", busy, 0);

        //   u  d  l  r  sel flg  px py  ex ey fl cell busy
        add(0, 0, 1, 0, 0, 0,   0, 0,  7, 0, 1, F, 0);
        add(0, 0, 0, 1, 0, 0,   0, 0,  0, 0, 1, F, 0);
        add(1, 0, 0, 0, 0, 0,   0, 0,  0, 7, 1, F, 0);
        add(0, 1, 0, 0, 0, 0,   0, 0,  0, 0, 1, F, 0);
        add(1, 1, 1, 1, 0, 0,   0, 0,  0, 0, 1, F, 0);
        add(0, 0, 0, 1, 0, 0,   0, 0,  1, 0, 1, F, 0);
        add(0, 0, 0, 1, 0, 0,   0, 0,  2, 0, 1, F, 0);
        add(0, 0, 0, 1, 0, 0,   0, 0,  3, 0, 1, F, 0);
        add(0, 1, 0, 0, 0, 0,   0, 0,  3, 1, 1, F, 0);
        add(0, 1, 0, 0, 0, 0,   0, 0,  3, 2, 1, F, 0);
        add(0, 1, 0, 0, 0, 0,   0, 0,  3, 3, 1, F, 0);
        add(0, 0, 0, 0, 0, 1,   3, 3,  3, 3, 0, E, 0);
        add(0, 0, 0, 0, 0, 1,   3, 3,  3, 3, 1, F, 0);
        add(0, 0, 0, 0, 0, 1,   3, 3,  3, 3, 0, E, 0);
        add(0, 0, 0, 1, 0, 0,   3, 3,  4, 3, 0, E, 0);
        add(0, 0, 0, 0, 0, 1,   4, 3,  4, 3, 0, F, 0);
        add(0, 0, 1, 0, 0, 0,   3, 3,  3, 3, 0, E, 0);
        add(0, 0, 0, 0, 0, 1,   3, 3,  3, 3, 1, F, 0);
        add(0, 0, 1, 0, 0, 0,   0, 0,  2, 3, 1, F, 0);
        add(1, 0, 0, 0, 0, 0,   0, 0,  2, 2, 1, F, 0);
        add(0, 0, 0, 1, 1, 1,   2, 2,  3, 2, 0, E, 0);
        add(0, 0, 0, 0, 0, 0,   2, 2,  3, 2, 0, E, 0);
        add(0, 0, 1, 0, 0, 0,   2, 2,  2, 2, 0, E, 0);
        add(0, 0, 0, 0, 0, 1,   2, 2,  2, 2, 1, F, 0);
        add(0, 0, 1, 0, 0, 0,   0, 0,  1, 2, 1, F, 0);
        add(1, 0, 0, 0, 0, 0,   0, 0,  1, 1, 1, F, 0);
        add(0, 0, 0, 0, 1, 0,   1, 1,  1, 1, 1, F, 1);
        add(0, 0, 0, 1, 0, 0,   1, 1,  2, 1, 1, 1, 1);
        add(0, 0, 0, 0, 0, 0,   1, 1,  2, 1, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0,   1, 1,  1, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0,   1, 1,  1, 1, 1, 1, 0);

        foreach (vecs[k]) begin
            pulse(vecs[k].u, vecs[k].d, vecs[k].l, vecs[k].r, vecs[k].sel, vecs[k].flg);
            check($sformatf("vec%0d_pos_x", k), pos_x, vecs[k].ex);
            check($sformatf("vec%0d_pos_y", k), pos_y, vecs[k].ey);
            check($sformatf("vec%0d_flags", k), flags_left, vecs[k].efl);
            check($sformatf("vec%0d_cell", k), mat[vecs[k].px][vecs[k].py], vecs[k].ecell);
            check($sformatf("vec%0d_busy", k), busy, vecs[k].ebusy);
        end
        check("table_no_win", win, 0);

        // Flood fill from (7,7) with single mine at (0,0)
        do_start(64'h1);
        pulse(1, 0, 1, 0, 0, 0);
        check("flood_pos", {pos_x, pos_y}, 6'o77);
        pulse(0, 0, 0, 0, 1, 0);
        n = 0;
        while (busy === 1'b1 && n < 6000) begin
            n++;
            tick();
        end
        check("flood_timeout", (n < 6000) ? 1 : 0, 1);
        check($sformatf("flood_busy_len_is_2_plus_64P(len=%0d)", n),
              (n >= 66 && (n - 2) % 64 == 0) ? 1 : 0, 1);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (i == 0 && j == 0) expc = F;
                else if (i <= 1 && j <= 1) expc = 1;
                else expc = 0;
                if (mat[i][j] != 4'(expc)) bad++;
            end
        end
        check("flood_bad_cells", bad, 0);
        check("flood_win", win, 1);
        check("flood_game_over", game_over, 0);
        pulse(0, 0, 0, 1, 0, 0);
        check("won_move_ignored", {pos_x, pos_y}, 6'o77);

        // Mine hit: mines at (0,0), (1,1), (7,7); (1,1) flagged first
        do_start(64'h8000_0000_0000_0201);
        check("mine_flags_start", flags_left, 3);
        pulse(0, 1, 0, 1, 0, 0);
        pulse(0, 0, 0, 0, 0, 1);
        check("mine_flag11", mat[1][1], E);
        pulse(1, 0, 1, 0, 0, 0);
        pulse(0, 0, 0, 0, 1, 0);
        check("mine_boom", mat[0][0], C);
        check("mine_shown77", mat[7][7], D);
        check("mine_flag_kept", mat[1][1], E);
        check("mine_game_over", game_over, 1);
        check("mine_busy", busy, 0);
        pulse(0, 0, 0, 1, 1, 1);
        pulse(0, 1, 0, 0, 0, 1);
        check("lost_pos", {pos_x, pos_y}, 0);
        check("lost_flags", flags_left, 2);
        check("lost_cell11", mat[1][1], E);
        check("lost_cell22", mat[2][2], F);
        check("lost_hold", game_over, 1);

        // Select dropped mid-sweep, then start aborts the sweep
        do_start(64'h1);
        pulse(1, 0, 1, 0, 0, 0);
        pulse(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) tick();
        check("sweep_busy", busy, 1);
        pulse(0, 1, 0, 1, 0, 0);
        check("sweep_move_accepted", {pos_x, pos_y}, 0);
        pulse(0, 0, 0, 0, 1, 0);
        check("sweep_select_dropped", game_over, 0);
        check("sweep_cell00", mat[0][0], F);
        do_start(64'h1);
        check("abort_cells_hidden", count_not(4'hF), 0);
        check("abort_busy", busy, 0);
        check("abort_flags", flags_left, 1);
        pulse(0, 0, 0, 0, 0, 1);
        check("abort_play_flag", mat[0][0], E);
        check("abort_play_flags", flags_left, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
